// File: rtl/serial_rx_deser.sv
// Async-serial receiver: synchronises the captured line bit and rebuilds framed words
// (start, LSB-first data, optional even parity, stop) with valid/parity/framing strobes.
module serial_rx_deser #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t                 state;
    logic   [CW-1:0]        cnt;
    logic   [BW-1:0]        bit_idx;
    logic   [DATA_BITS-1:0] shift;
    logic                   perr;
    logic                   sync1;
    logic                   rxs;
    logic                   rxs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            rxs_d      <= 1'b1;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sync1      <= rxd;
            rxs        <= sync1;
            rxs_d      <= rxs;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    // Only a high-to-low transition starts a frame; a held-low line is ignored.
                    if (rxs_d && !rxs) begin
                        state <= StStart;
                        busy  <= 1'b1;
                    end
                end

                StStart: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= StData;
                            bit_idx <= '0;
                            perr    <= 1'b0;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                StData: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rxs, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == BIT_LAST) begin
                            state <= (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                StParity: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        perr  <= (^shift) ^ rxs;
                        state <= StStop;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                StStop: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= StIdle;
                        busy  <= 1'b0;
                        if (rxs) begin
                            data       <= shift;
                            valid      <= 1'b1;
                            parity_err <= (PARITY_EN != 0) && perr;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
